mc_main_ctrl: RTL and testbench

Multicycle MIPS main control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback steps. It produces every datapath enable, plus the 2-bit aluOp that the ALU-control decoder consumes (00 add, 01 subtract, 10 decode funct). It sits between the instruction register's opcode field and the datapath. A memory-ready handshake stretches memory states, and a retired-instruction counter supports board debug.

---
 rtl/mc_main_ctrl_pkg.sv | 56 +++++
 rtl/mc_ctrl_outdec.sv | 66 ++++++
 rtl/mc_main_ctrl.sv | 111 +++++++++++
 tb/tb_mc_main_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mc_main_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, FSM states,
// ALU/PC select codes and the packed control word driven into the datapath.
package mc_main_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_R_WB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_EXEC_I  = 4'd10,
    S_I_WB    = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control-word decode, zero latency, no handshake.
// FETCH leaves pcWrite/irWrite low here; the parent qualifies them with mem_ready.
module mc_ctrl_outdec
  import mc_main_ctrl_pkg::*;
(
  input  state_e i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADR, S_EXEC_I: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.ior_d     = 1'b1;
      end
      S_EXEC_R: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_REG;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      S_I_WB: begin
        o_ctrl.reg_write = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control: Moore FSM with retired-instruction counter.
// Outputs decode the registered state; mem_ready stalls FETCH/MEM_RD/MEM_WR.
module mc_main_ctrl
  import mc_main_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pcWrite,
  output logic             pcWriteCond,
  output logic             iorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             memToReg,
  output logic             regDst,
  output logic             regWrite,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       pcSource,
  output logic [1:0]       aluOp,
  output logic [3:0]       state,
  output logic             illegalOp,
  output logic [CNT_W-1:0] instrCount
);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  ctrl_t            w_dec;
  logic             w_rdy;
  logic             w_retire;
  logic             w_illegal;
  logic             w_fetch_go;

  assign w_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next    = S_FETCH;
    w_retire  = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = S_EXEC_R;
          OP_LW, OP_SW: w_next = S_MEM_ADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_EXEC_I;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  w_next = w_rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR: begin
        w_next   = w_rdy ? S_FETCH : S_MEM_WR;
        w_retire = w_rdy;
      end
      S_EXEC_R: w_next = S_R_WB;
      S_EXEC_I: w_next = S_I_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .i_state (r_state),
    .o_ctrl  (w_dec)
  );

  // Everything is forced low while reset is held, even though state reads FETCH.
  assign w_fetch_go  = (r_state == S_FETCH) && w_rdy;
  assign pcWrite     = rst_n & (w_dec.pc_write | w_fetch_go);
  assign irWrite     = rst_n & (w_dec.ir_write | w_fetch_go);
  assign pcWriteCond = rst_n & w_dec.pc_write_cond;
  assign iorD        = rst_n & w_dec.ior_d;
  assign memRead     = rst_n & w_dec.mem_read;
  assign memWrite    = rst_n & w_dec.mem_write;
  assign memToReg    = rst_n & w_dec.mem_to_reg;
  assign regDst      = rst_n & w_dec.reg_dst;
  assign regWrite    = rst_n & w_dec.reg_write;
  assign aluSrcA     = rst_n & w_dec.alu_src_a;
  assign aluSrcB     = rst_n ? w_dec.alu_src_b : 2'b00;
  assign pcSource    = rst_n ? w_dec.pc_source : 2'b00;
  assign aluOp       = rst_n ? w_dec.alu_op : 2'b00;
  assign illegalOp   = rst_n & w_illegal;
  assign state       = r_state;
  assign instrCount  = r_cnt;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: per-cycle control word and counter checks,
// with a CNT_W=4 twin sharing the stimulus to exercise counter wrap.
module tb_mc_main_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        mem_ready = 1'b1;

  logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic        memToReg, regDst, regWrite, aluSrcA, illegalOp;
  logic [1:0]  aluSrcB, pcSource, aluOp;
  logic [3:0]  state;
  logic [31:0] instrCount;

  logic        pcWrite4, pcWriteCond4, iorD4, memRead4, memWrite4, irWrite4;
  logic        memToReg4, regDst4, regWrite4, aluSrcA4, illegalOp4;
  logic [1:0]  aluSrcB4, pcSource4, aluOp4;
  logic [3:0]  state4;
  logic [3:0]  instrCount4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mc_main_ctrl #(.CNT_W(32), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSource(pcSource),
    .aluOp(aluOp), .state(state), .illegalOp(illegalOp),
    .instrCount(instrCount)
  );

  mc_main_ctrl #(.CNT_W(4), .MEM_WAIT_EN(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcWrite(pcWrite4), .pcWriteCond(pcWriteCond4), .iorD(iorD4),
    .memRead(memRead4), .memWrite(memWrite4), .irWrite(irWrite4),
    .memToReg(memToReg4), .regDst(regDst4), .regWrite(regWrite4),
    .aluSrcA(aluSrcA4), .aluSrcB(aluSrcB4), .pcSource(pcSource4),
    .aluOp(aluOp4), .state(state4), .illegalOp(illegalOp4),
    .instrCount(instrCount4)
  );

  // {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,memToReg,regDst,regWrite,aluSrcA,aluSrcB,pcSource,aluOp,state,illegalOp}
  wire [20:0] w_obs = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                       memToReg, regDst, regWrite, aluSrcA, aluSrcB, pcSource,
                       aluOp, state, illegalOp};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference control word built from the state table.
  function automatic logic [20:0] exp_ctl(input int st, input bit rdy, input bit ill);
    logic pw = 0, pwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00, op = 2'b00;
    case (st)
      0:  begin mr = 1; sb = 2'b01; pw = rdy; irw = rdy; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; op = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ps, op, 4'(st), ill};
  endfunction

  // One clock cycle: set mem_ready, check outputs mid-cycle, advance to next negedge.
  task automatic cyc(input string tag, input int st, input bit rdy, input bit ill, input int cnt);
    mem_ready = rdy;
    #1;
    chk({tag, " ctl"}, 64'(w_obs), 64'(exp_ctl(st, rdy, ill)));
    chk({tag, " cnt"}, 64'(instrCount), 64'(cnt));
    chk({tag, " cnt4"}, 64'(instrCount4), 64'(cnt % 16));
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    // Reset held: every output low, counters zero.
    repeat (2) @(negedge clk);
    #1;
    chk("rst ctl", 64'(w_obs), 64'd0);
    chk("rst cnt", 64'(instrCount), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type: 0,1,6,7 then retire.
    opcode = 6'b000000;
    cyc("r fetch", 0, 1, 0, 0);
    cyc("r dec",   1, 1, 0, 0);
    cyc("r exec",  6, 1, 0, 0);
    cyc("r wb",    7, 1, 0, 0);

    // lw with one FETCH stall and three MEM_RD stalls.
    opcode = 6'b100011;
    cyc("lw fetch stall", 0, 0, 0, 1);
    cyc("lw fetch",       0, 1, 0, 1);
    cyc("lw dec",         1, 1, 0, 1);
    cyc("lw adr",         2, 1, 0, 1);
    cyc("lw rd w1",       3, 0, 0, 1);
    cyc("lw rd w2",       3, 0, 0, 1);
    cyc("lw rd w3",       3, 0, 0, 1);
    cyc("lw rd",          3, 1, 0, 1);
    cyc("lw wb",          4, 1, 0, 1);

    // beq then sw.
    opcode = 6'b000100;
    cyc("beq fetch", 0, 1, 0, 2);
    cyc("beq dec",   1, 1, 0, 2);
    cyc("beq br",    8, 1, 0, 2);
    opcode = 6'b101011;
    cyc("sw fetch", 0, 1, 0, 3);
    cyc("sw dec",   1, 1, 0, 3);
    cyc("sw adr",   2, 1, 0, 3);
    cyc("sw wr",    5, 1, 0, 3);

    // addi.
    opcode = 6'b001000;
    cyc("addi fetch", 0, 1, 0, 4);
    cyc("addi dec",   1, 1, 0, 4);
    cyc("addi exec", 10, 1, 0, 4);
    cyc("addi wb",   11, 1, 0, 4);

    // Illegal opcode: pulse in DECODE, no retire.
    opcode = 6'b111111;
    cyc("ill fetch", 0, 1, 0, 5);
    cyc("ill dec",   1, 1, 1, 5);
    cyc("ill back",  0, 1, 0, 5);
    cyc("ill dec2",  1, 1, 1, 5);

    // 16 jumps: the 4-bit twin wraps back to 0.
    opcode = 6'b000010;
    cnt = 5;
    for (int i = 0; i < 16; i++) begin
      cyc("j fetch", 0, 1, 0, cnt);
      cyc("j dec",   1, 1, 0, cnt);
      cyc("j jump",  9, 1, 0, cnt);
      cnt++;
    end

    // lw interrupted by asynchronous reset in MEM_RD.
    opcode = 6'b100011;
    cyc("lwr fetch", 0, 1, 0, cnt);
    cyc("lwr dec",   1, 1, 0, cnt);
    cyc("lwr adr",   2, 1, 0, cnt);
    mem_ready = 1'b0;
    #1;
    chk("lwr rd ctl", 64'(w_obs), 64'(exp_ctl(3, 0, 0)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst ctl",  64'(w_obs), 64'd0);
    chk("arst cnt",  64'(instrCount), 64'd0);
    chk("arst cnt4", 64'(instrCount4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post rst fetch", 0, 1, 0, 0);
    cyc("post rst dec",   1, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
